// File: rtl/axi4_pkg.sv
// Shared AXI4 definitions: response/burst codes and the slave FSM state type.
package axi4_pkg;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WDATA = 2'd1,
    WRESP = 2'd2,
    RDATA = 2'd3
  } state_e;

endpackage

// File: rtl/axi4_ifc.sv
// AXI4 bundle with 32-bit address/data and IWIDTH-bit IDs.
interface axi4_ifc #(parameter int IWIDTH = 5);

  // Write address channel
  logic              awvalid;
  logic              awready;
  logic [31:0]       awaddr;
  logic [7:0]        awlen;
  logic [IWIDTH-1:0] awid;
  logic [1:0]        awburst;
  logic [2:0]        awsize;
  logic [3:0]        awcache;
  logic [2:0]        awprot;
  logic              awlock;
  logic [3:0]        awqos;
  // Write data channel
  logic              wvalid;
  logic              wready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wlast;
  // Write response channel
  logic              bvalid;
  logic              bready;
  logic [IWIDTH-1:0] bid;
  logic [1:0]        bresp;
  // Read address channel
  logic              arvalid;
  logic              arready;
  logic [31:0]       araddr;
  logic [7:0]        arlen;
  logic [IWIDTH-1:0] arid;
  logic [1:0]        arburst;
  logic [2:0]        arsize;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic              arlock;
  logic [3:0]        arqos;
  // Read data channel
  logic              rvalid;
  logic              rready;
  logic [31:0]       rdata;
  logic [IWIDTH-1:0] rid;
  logic [1:0]        rresp;
  logic              rlast;

  modport slave (
    input  awvalid, awaddr, awlen, awid, awburst, awsize, awcache, awprot, awlock, awqos,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bid, bresp,
    input  bready,
    input  arvalid, araddr, arlen, arid, arburst, arsize, arcache, arprot, arlock, arqos,
    output arready,
    output rvalid, rdata, rid, rresp, rlast,
    input  rready
  );

  modport master (
    output awvalid, awaddr, awlen, awid, awburst, awsize, awcache, awprot, awlock, awqos,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bid, bresp,
    output bready,
    output arvalid, araddr, arlen, arid, arburst, arsize, arcache, arprot, arlock, arqos,
    input  arready,
    input  rvalid, rdata, rid, rresp, rlast,
    output rready
  );

endinterface

// File: rtl/sram_bytewe.sv
// 2^AWIDTH x 32 word memory, per-byte write enables, registered read port.
// Contents are not touched by reset; only the read register is cleared.
module sram_bytewe #(
  parameter int AWIDTH = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        i_we,
  input  logic [AWIDTH-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  input  logic              i_re,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [0:(1<<AWIDTH)-1];

  // Byte-lane writes into the array
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_we[b]) begin
        r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  // Synchronous read; the register holds its value when i_re is low
  always_ff @(posedge clk) begin
    if (reset) begin
      o_rdata <= 32'd0;
    end else if (i_re) begin
      o_rdata <= r_mem[i_addr];
    end
  end

endmodule

// File: rtl/axi4_sram_slave.sv
// AXI4 INCR-burst slave in front of a word-addressed SRAM, one transaction
// at a time. Reads prefetch: the word for beat k+1 is fetched on the
// handshake of beat k, so the pointer always holds the next fetch address.
module axi4_sram_slave
  import axi4_pkg::*;
#(
  parameter int IWIDTH = 5,
  parameter int AWIDTH = 10
) (
  input logic      clk,
  input logic      reset,
  axi4_ifc.slave   s
);

  localparam logic [AWIDTH-1:0] PTR_ONE = {{(AWIDTH-1){1'b0}}, 1'b1};

  state_e            r_state;
  logic              r_rdy;
  logic              r_wready;
  logic              r_bvalid;
  logic              r_rvalid;
  logic              r_rlast;
  logic [AWIDTH-1:0] r_ptr;
  logic [7:0]        r_len;
  logic [7:0]        r_beat;
  logic [IWIDTH-1:0] r_bid;
  logic [IWIDTH-1:0] r_rid;

  logic              w_aw_hs;
  logic              w_ar_hs;
  logic              w_w_hs;
  logic              w_w_last;
  logic              w_r_hs;
  logic [AWIDTH-1:0] w_aw_ptr;
  logic [AWIDTH-1:0] w_ar_ptr;
  logic [AWIDTH-1:0] w_mem_addr;
  logic [3:0]        w_mem_we;
  logic              w_mem_re;
  logic [31:0]       w_rdata;
  logic              w_unused;

  // Write has priority: arready is masked whenever awvalid is present.
  assign w_aw_hs  = s.awvalid & r_rdy;
  assign w_ar_hs  = s.arvalid & r_rdy & ~s.awvalid;
  assign w_w_hs   = s.wvalid & r_wready;
  assign w_w_last = w_w_hs & (s.wlast | (r_beat == r_len));
  assign w_r_hs   = r_rvalid & s.rready;

  assign w_aw_ptr = s.awaddr[AWIDTH+1:2];
  assign w_ar_ptr = s.araddr[AWIDTH+1:2];

  // In IDLE the array is addressed straight from araddr so the first read
  // word is registered on the AR handshake edge.
  assign w_mem_addr = (r_state == IDLE) ? w_ar_ptr : r_ptr;
  assign w_mem_we   = {4{w_w_hs}} & s.wstrb;
  assign w_mem_re   = w_ar_hs | w_r_hs;

  sram_bytewe #(.AWIDTH(AWIDTH)) u_sram (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_mem_we),
    .i_addr  (w_mem_addr),
    .i_wdata (s.wdata),
    .i_re    (w_mem_re),
    .o_rdata (w_rdata)
  );

  // Transaction FSM and channel handshake registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_rdy    <= 1'b0;
      r_wready <= 1'b0;
      r_bvalid <= 1'b0;
      r_rvalid <= 1'b0;
      r_rlast  <= 1'b0;
      r_ptr    <= '0;
      r_len    <= 8'd0;
      r_beat   <= 8'd0;
      r_bid    <= '0;
      r_rid    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_aw_hs) begin
            r_ptr    <= w_aw_ptr;
            r_len    <= s.awlen;
            r_beat   <= 8'd0;
            r_bid    <= s.awid;
            r_wready <= 1'b1;
            r_rdy    <= 1'b0;
            r_state  <= WDATA;
          end else if (w_ar_hs) begin
            r_ptr    <= w_ar_ptr + PTR_ONE;
            r_len    <= s.arlen;
            r_beat   <= 8'd0;
            r_rid    <= s.arid;
            r_rvalid <= 1'b1;
            r_rlast  <= (s.arlen == 8'd0);
            r_rdy    <= 1'b0;
            r_state  <= RDATA;
          end else begin
            r_rdy    <= 1'b1;
          end
        end
        WDATA: begin
          if (w_w_hs) begin
            r_ptr  <= r_ptr + PTR_ONE;
            r_beat <= r_beat + 8'd1;
          end
          if (w_w_last) begin
            r_wready <= 1'b0;
            r_bvalid <= 1'b1;
            r_state  <= WRESP;
          end
        end
        WRESP: begin
          if (s.bready) begin
            r_bvalid <= 1'b0;
            r_rdy    <= 1'b1;
            r_state  <= IDLE;
          end
        end
        RDATA: begin
          if (w_r_hs) begin
            if (r_rlast) begin
              r_rvalid <= 1'b0;
              r_rlast  <= 1'b0;
              r_rdy    <= 1'b1;
              r_state  <= IDLE;
            end else begin
              r_ptr   <= r_ptr + PTR_ONE;
              r_beat  <= r_beat + 8'd1;
              r_rlast <= ((r_beat + 8'd1) == r_len);
            end
          end
        end
        default: begin
          r_state  <= IDLE;
          r_rdy    <= 1'b0;
          r_wready <= 1'b0;
          r_bvalid <= 1'b0;
          r_rvalid <= 1'b0;
          r_rlast  <= 1'b0;
        end
      endcase
    end
  end

  assign s.awready = r_rdy;
  assign s.arready = r_rdy & ~s.awvalid;
  assign s.wready  = r_wready;
  assign s.bvalid  = r_bvalid;
  assign s.bid     = r_bid;
  assign s.bresp   = RESP_OKAY;
  assign s.rvalid  = r_rvalid;
  assign s.rdata   = w_rdata;
  assign s.rid     = r_rid;
  assign s.rresp   = RESP_OKAY;
  assign s.rlast   = r_rlast;

  // Attributes every burst ignores (always INCR of 4-byte beats), plus the
  // aliased upper and byte-offset address bits.
  assign w_unused = ^{s.awaddr[31:AWIDTH+2], s.awaddr[1:0], s.awburst, s.awsize,
                      s.awcache, s.awprot, s.awlock, s.awqos,
                      s.araddr[31:AWIDTH+2], s.araddr[1:0], s.arburst, s.arsize,
                      s.arcache, s.arprot, s.arlock, s.arqos};

endmodule

// File: tb/tb_axi4_sram_slave.sv
// Randomized bench for axi4_sram_slave with a word-array memory model and
// queue-based expectations for the R and B channels.
module tb_axi4_sram_slave;
  import axi4_pkg::*;

  localparam int IW    = 5;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  axi4_ifc #(.IWIDTH(IW)) bus ();

  axi4_sram_slave #(.IWIDTH(IW), .AWIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .s     (bus)
  );

  typedef struct {
    logic [31:0]   data;
    logic [IW-1:0] id;
    logic          last;
  } rbeat_t;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [31:0]   mem_m [DEPTH];
  rbeat_t        exp_r [$];
  logic [IW-1:0] exp_b [$];
  logic [31:0]   rd_cap [$];
  logic [31:0]   wq_data [$];
  logic [3:0]    wq_strb [$];

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle compare of R and B channels against the expectation queues
  logic        prev_stall = 1'b0;
  logic [31:0] prev_rdata = 32'd0;
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_eq("r_hold_valid", bus.rvalid, 1);
        check_eq("r_hold_data", bus.rdata, prev_rdata);
      end
      if (bus.rvalid) begin
        if (exp_r.size() == 0) begin
          check_eq("r_unexpected", 1, 0);
        end else begin
          check_eq("rdata", bus.rdata, exp_r[0].data);
          check_eq("rid", bus.rid, exp_r[0].id);
          check_eq("rlast", bus.rlast, exp_r[0].last);
          check_eq("rresp", bus.rresp, RESP_OKAY);
          if (bus.rready) void'(exp_r.pop_front());
        end
      end
      if (bus.bvalid) begin
        if (exp_b.size() == 0) begin
          check_eq("b_unexpected", 1, 0);
        end else begin
          check_eq("bid", bus.bid, exp_b[0]);
          check_eq("bresp", bus.bresp, RESP_OKAY);
          if (bus.bready) void'(exp_b.pop_front());
        end
      end
      prev_stall = bus.rvalid & ~bus.rready;
      prev_rdata = bus.rdata;
    end
  end

  task automatic wait_aw(output bit hs);
    int n = 0;
    hs = 1'b0;
    while (!hs && n < 200) begin
      @(negedge clk);
      hs = bus.awready;
      n++;
      tick();
    end
  endtask

  task automatic wait_ar(output bit hs);
    int n = 0;
    hs = 1'b0;
    while (!hs && n < 200) begin
      @(negedge clk);
      hs = bus.arready;
      n++;
      tick();
    end
  endtask

  // Drive the W beats from wq_*, updating the model on each accepted beat
  task automatic w_phase(input logic [31:0] addr, input logic [7:0] len, input bit gaps);
    bit hs;
    int n;
    logic [AW-1:0] p;
    p = addr[AW+1:2];
    for (int i = 0; i <= int'(len); i++) begin
      if (gaps && i > 0 && $urandom_range(0, 2) == 0) begin
        bus.wvalid = 1'b0;
        repeat ($urandom_range(1, 2)) tick();
      end
      bus.wvalid = 1'b1;
      bus.wdata  = wq_data[i];
      bus.wstrb  = wq_strb[i];
      bus.wlast  = (i == int'(len));
      hs = 1'b0;
      n  = 0;
      while (!hs && n < 200) begin
        @(negedge clk);
        if (i == 0 && n == 0) check_eq("w_ready_lat", bus.wready, 1);
        hs = bus.wready;
        n++;
        tick();
      end
      if (!hs) begin
        check_eq("w_timeout", 0, 1);
        bus.wvalid = 1'b0;
        return;
      end
      for (int b = 0; b < 4; b++) begin
        if (wq_strb[i][b]) mem_m[p][8*b +: 8] = wq_data[i][8*b +: 8];
      end
      p++;
    end
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
  endtask

  task automatic b_phase(input bit gaps, output bit r_seen);
    bit hs = 1'b0;
    int n = 0;
    r_seen = 1'b0;
    while (!hs && n < 200) begin
      bus.bready = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (n == 0) check_eq("b_lat", bus.bvalid, 1);
      if (bus.rvalid) r_seen = 1'b1;
      hs = bus.bvalid & bus.bready;
      n++;
      tick();
    end
    bus.bready = 1'b0;
    if (!hs) check_eq("b_timeout", 0, 1);
  endtask

  task automatic push_exp_r(input logic [31:0] addr, input logic [7:0] len, input logic [IW-1:0] id);
    logic [AW-1:0] p;
    p = addr[AW+1:2];
    for (int i = 0; i <= int'(len); i++) begin
      exp_r.push_back('{data: mem_m[p], id: id, last: (i == int'(len))});
      p++;
    end
  endtask

  // mode 0: rready held high, 1: toggles every other cycle, 2: random
  task automatic r_phase(input logic [7:0] len, input int mode);
    int got = 0;
    int cyc = 0;
    rd_cap.delete();
    while (got <= int'(len) && cyc < 2000) begin
      case (mode)
        0:       bus.rready = 1'b1;
        1:       bus.rready = (cyc % 2 == 1);
        default: bus.rready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (cyc == 0) check_eq("r_valid_lat", bus.rvalid, 1);
      if (bus.rvalid && bus.rready) begin
        rd_cap.push_back(bus.rdata);
        got++;
      end
      cyc++;
      tick();
    end
    bus.rready = 1'b0;
    if (got <= int'(len)) check_eq("r_timeout", got, int'(len) + 1);
    check_eq("r_leftover", exp_r.size(), 0);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [IW-1:0] id, input bit gaps);
    bit hs;
    bit r_seen;
    exp_b.push_back(id);
    bus.awaddr  = addr;
    bus.awlen   = len;
    bus.awid    = id;
    bus.awvalid = 1'b1;
    wait_aw(hs);
    bus.awvalid = 1'b0;
    if (!hs) begin
      check_eq("aw_timeout", 0, 1);
      exp_b.delete();
      return;
    end
    w_phase(addr, len, gaps);
    b_phase(gaps, r_seen);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [IW-1:0] id, input int mode);
    bit hs;
    push_exp_r(addr, len, id);
    bus.araddr  = addr;
    bus.arlen   = len;
    bus.arid    = id;
    bus.arvalid = 1'b1;
    wait_ar(hs);
    bus.arvalid = 1'b0;
    if (!hs) begin
      check_eq("ar_timeout", 0, 1);
      exp_r.delete();
      return;
    end
    r_phase(len, mode);
  endtask

  task automatic fill_wq(input logic [7:0] len, input logic [31:0] base, input bit rnd);
    wq_data.delete();
    wq_strb.delete();
    for (int i = 0; i <= int'(len); i++) begin
      wq_data.push_back(rnd ? 32'($urandom) : base + 32'(i));
      wq_strb.push_back(rnd ? 4'($urandom_range(0, 15)) : 4'hF);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit hs;
    bit r_seen;
    logic [31:0] addr;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'd0;
    bus.awvalid = 1'b0; bus.awaddr = 32'd0; bus.awlen = 8'd0; bus.awid = '0;
    bus.awburst = BURST_INCR; bus.awsize = 3'd2; bus.awcache = 4'd0;
    bus.awprot = 3'd0; bus.awlock = 1'b0; bus.awqos = 4'd0;
    bus.wvalid = 1'b0; bus.wdata = 32'd0; bus.wstrb = 4'd0; bus.wlast = 1'b0;
    bus.bready = 1'b0;
    bus.arvalid = 1'b0; bus.araddr = 32'd0; bus.arlen = 8'd0; bus.arid = '0;
    bus.arburst = BURST_INCR; bus.arsize = 3'd2; bus.arcache = 4'd0;
    bus.arprot = 3'd0; bus.arlock = 1'b0; bus.arqos = 4'd0;
    bus.rready = 1'b0;

    // Reset values
    repeat (3) tick();
    @(negedge clk);
    check_eq("rst_awready", bus.awready, 0);
    check_eq("rst_arready", bus.arready, 0);
    check_eq("rst_wready", bus.wready, 0);
    check_eq("rst_bvalid", bus.bvalid, 0);
    check_eq("rst_rvalid", bus.rvalid, 0);
    check_eq("rst_rlast", bus.rlast, 0);
    check_eq("rst_rdata", bus.rdata, 0);
    check_eq("rst_rid", bus.rid, 0);
    check_eq("rst_bid", bus.bid, 0);
    check_eq("rst_rresp", bus.rresp, 0);
    check_eq("rst_bresp", bus.bresp, 0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("post_rst_awready", bus.awready, 1);
    check_eq("post_rst_arready", bus.arready, 1);
    tick();

    // 8-beat write at 0 then readback
    fill_wq(8'd7, 32'h1000, 1'b0);
    do_write(32'h0, 8'd7, 5'd5, 1'b0);
    do_read(32'h0, 8'd7, 5'd9, 0);
    for (int i = 0; i < 8; i++) check_eq("burst8_data", rd_cap[i], 32'h1000 + 32'(i));

    // Unwritten region with rready toggling
    do_read(32'h40, 8'd7, 5'd3, 1);
    check_eq("unwr_count", rd_cap.size(), 8);
    for (int i = 0; i < rd_cap.size(); i++) check_eq("unwr_data", rd_cap[i], 32'd0);

    // Partial write through wstrb
    wq_data = '{32'hAABBCCDD}; wq_strb = '{4'hF};
    do_write(32'h0, 8'd0, 5'd1, 1'b0);
    wq_data = '{32'h11223344}; wq_strb = '{4'b0101};
    do_write(32'h0, 8'd0, 5'd1, 1'b0);
    do_read(32'h0, 8'd0, 5'd2, 0);
    check_eq("partial_model", mem_m[0], 32'hAA22CC44);
    check_eq("partial_data", rd_cap[0], 32'hAA22CC44);

    // Simultaneous AW and AR: write goes first, read sees new data
    exp_b.push_back(5'd2);
    bus.awaddr = 32'h80; bus.awlen = 8'd0; bus.awid = 5'd2;
    bus.araddr = 32'h80; bus.arlen = 8'd0; bus.arid = 5'd4;
    bus.awvalid = 1'b1; bus.arvalid = 1'b1;
    @(negedge clk);
    check_eq("arb_awready", bus.awready, 1);
    check_eq("arb_arready", bus.arready, 0);
    tick();
    bus.awvalid = 1'b0;
    wq_data = '{32'hDEADBEEF}; wq_strb = '{4'hF};
    w_phase(32'h80, 8'd0, 1'b0);
    b_phase(1'b0, r_seen);
    check_eq("arb_b_before_r", r_seen, 0);
    push_exp_r(32'h80, 8'd0, 5'd4);
    wait_ar(hs);
    bus.arvalid = 1'b0;
    if (!hs) check_eq("arb_ar_timeout", 0, 1);
    else r_phase(8'd0, 0);
    check_eq("arb_data", rd_cap[0], 32'hDEADBEEF);

    // Address wrap at the top of memory
    fill_wq(8'd3, 32'hC0DE0000, 1'b0);
    do_write(32'((DEPTH - 2) * 4), 8'd3, 5'd7, 1'b1);
    do_read(32'((DEPTH - 2) * 4), 8'd3, 5'd8, 0);
    for (int i = 0; i < 4; i++) check_eq("wrap_data", rd_cap[i], 32'hC0DE0000 + 32'(i));
    do_read(32'h0, 8'd1, 5'd8, 2);
    check_eq("wrap_low0", rd_cap[0], 32'hC0DE0002);
    check_eq("wrap_low1", rd_cap[1], 32'hC0DE0003);

    // Reset in the middle of a read burst
    push_exp_r(32'h0, 8'd7, 5'd6);
    bus.araddr = 32'h0; bus.arlen = 8'd7; bus.arid = 5'd6; bus.arvalid = 1'b1;
    wait_ar(hs);
    bus.arvalid = 1'b0;
    if (!hs) check_eq("rst_ar_timeout", 0, 1);
    begin
      int got = 0;
      int cyc = 0;
      while (got < 3 && cyc < 100) begin
        bus.rready = 1'b1;
        @(negedge clk);
        if (bus.rvalid) got++;
        cyc++;
        tick();
      end
    end
    bus.rready = 1'b0;
    reset = 1'b1;
    tick();
    @(negedge clk);
    check_eq("midrst_rvalid", bus.rvalid, 0);
    check_eq("midrst_arready", bus.arready, 0);
    exp_r.delete();
    reset = 1'b0;
    @(negedge clk);
    check_eq("midrst_arready_rel", bus.arready, 1);
    tick();
    do_read(32'h0, 8'd7, 5'd11, 0);
    check_eq("midrst_data0", rd_cap[0], 32'hC0DE0002);

    // Randomized traffic, including aliased upper address bits
    for (int t = 0; t < 40; t++) begin
      logic [7:0] len;
      addr = $urandom;
      addr[AW+1:2] = AW'($urandom_range(0, 63));
      len = 8'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        fill_wq(len, 32'd0, 1'b1);
        do_write(addr, len, IW'($urandom), 1'b1);
      end else begin
        do_read(addr, len, IW'($urandom), int'($urandom_range(0, 2)));
      end
    end

    // Maximum-length burst
    fill_wq(8'd255, 32'd0, 1'b1);
    do_write(32'h400, 8'd255, 5'd30, 1'b0);
    do_read(32'h400, 8'd255, 5'd31, 0);
    check_eq("long_count", rd_cap.size(), 256);

    repeat (5) tick();
    check_eq("final_exp_r", exp_r.size(), 0);
    check_eq("final_exp_b", exp_b.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
